// File: rtl/bioee_pkg.sv
// Shared types and default widths for the cyclic-voltammetry sweep sequencer.
package bioee_pkg;
    localparam int CODE_W_DEF = 16;
    localparam int CYC_W_DEF  = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    typedef enum logic [1:0] {PH_UP, PH_DOWN, PH_RET} phase_t;
endpackage

// File: rtl/bioee_sweep_sequencer_if.sv
// DAC sample stream: code plus valid/ready handshake toward the serializer.
interface bioee_sweep_sequencer_if #(parameter int CODE_W = 16);
    logic [CODE_W-1:0] dac_code;
    logic              dac_valid;
    logic              dac_ready;

    modport master (output dac_code, output dac_valid, input dac_ready);
    modport slave  (input dac_code, input dac_valid, output dac_ready);
endinterface

// File: rtl/bioee_edge_tick.sv
// Two-flop rising-edge detector for a divider output sampled in the clkin domain.
module bioee_edge_tick (
    input  logic clkin,
    input  logic rstn,
    input  logic lvl,
    output logic tick
);
    logic s0, s1;

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= lvl;
            s1 <= s0;
        end
    end

    assign tick = s0 & ~s1;
endmodule

// File: rtl/bioee_sweep_sequencer.sv
// Triangle-sweep DAC code generator: start -> vertex_hi -> vertex_lo -> start, one step per tick.
module bioee_sweep_sequencer
    import bioee_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int CYC_W  = CYC_W_DEF
) (
    input  logic                     clkin,
    input  logic                     rstn,
    input  logic                     step_clk,
    input  logic                     go,
    input  logic                     abort,
    input  logic [CODE_W-1:0]        start_code,
    input  logic [CODE_W-1:0]        vertex_hi,
    input  logic [CODE_W-1:0]        vertex_lo,
    input  logic [CODE_W-1:0]        step_size,
    input  logic [CYC_W-1:0]         num_cycles,
    bioee_sweep_sequencer_if.master  dac,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     overrun,
    output logic                     dir_up,
    output logic [CYC_W-1:0]         cycle_count
);
    logic tick;

    bioee_edge_tick u_tick (
        .clkin (clkin),
        .rstn  (rstn),
        .lvl   (step_clk),
        .tick  (tick)
    );

    state_t            state, state_nxt;
    phase_t            phase, nxt_phase;
    logic [CODE_W-1:0] start_q, hi_q, lo_q, step_q, code_q, nxt_code;
    logic [CYC_W-1:0]  ncyc_q, cyc_q;
    logic              valid_q, busy_q, done_q, cfg_err_q, ovr_q, dir_q, nxt_dir;
    logic              cfg_ok, go_acc, go_rej, hs, advance, ovr_hit, cyc_end, last_cyc;
    logic [CODE_W:0]   sum, diff;

    assign cfg_ok  = (vertex_lo <= start_code) && (start_code <= vertex_hi) &&
                     (step_size != '0) && (num_cycles != '0);
    assign go_acc  = (state == ST_IDLE) && go && !abort && cfg_ok;
    assign go_rej  = (state == ST_IDLE) && go && !abort && !cfg_ok;
    assign hs      = valid_q && dac.dac_ready;
    // A tick that lands while a sample is still pending (even on its handshake cycle) is dropped.
    assign advance = (state == ST_RUN) && tick && !valid_q;
    assign ovr_hit = (state == ST_RUN) && tick && valid_q;

    // Extra MSB keeps the add/subtract from wrapping before the vertex clamp.
    assign sum  = {1'b0, code_q} + {1'b0, step_q};
    assign diff = {1'b0, code_q} - {1'b0, step_q};

    always_comb begin
        nxt_code  = code_q;
        nxt_phase = phase;
        nxt_dir   = dir_q;
        cyc_end   = 1'b0;
        case (phase)
            PH_UP: begin
                if (sum >= {1'b0, hi_q}) begin
                    nxt_code  = hi_q;
                    nxt_phase = PH_DOWN;
                    nxt_dir   = 1'b0;
                end else begin
                    nxt_code = sum[CODE_W-1:0];
                end
            end
            PH_DOWN: begin
                if (diff[CODE_W] || (diff[CODE_W-1:0] <= lo_q)) begin
                    nxt_code = lo_q;
                    if (lo_q == start_q) begin
                        cyc_end = 1'b1;
                    end else begin
                        nxt_phase = PH_RET;
                        nxt_dir   = 1'b1;
                    end
                end else begin
                    nxt_code = diff[CODE_W-1:0];
                end
            end
            default: begin
                if (sum >= {1'b0, start_q}) begin
                    nxt_code = start_q;
                    cyc_end  = 1'b1;
                end else begin
                    nxt_code = sum[CODE_W-1:0];
                end
            end
        endcase
        // A new cycle starts at start_code; if that is already vertex_hi the UP leg is empty.
        if (cyc_end) begin
            nxt_phase = (start_q == hi_q) ? PH_DOWN : PH_UP;
            nxt_dir   = (start_q != hi_q);
        end
    end

    assign last_cyc = cyc_end && ((cyc_q + CYC_W'(1)) == ncyc_q);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go_acc) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                    state_nxt = ST_IDLE;
                else if (advance && last_cyc) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (abort || hs) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            start_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            step_q    <= '0;
            ncyc_q    <= '0;
            code_q    <= '0;
            cyc_q     <= '0;
            phase     <= PH_UP;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            dir_q     <= 1'b1;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (hs) valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_acc) begin
                        start_q <= start_code;
                        hi_q    <= vertex_hi;
                        lo_q    <= vertex_lo;
                        step_q  <= step_size;
                        ncyc_q  <= num_cycles;
                        code_q  <= start_code;
                        cyc_q   <= '0;
                        phase   <= (start_code == vertex_hi) ? PH_DOWN : PH_UP;
                        dir_q   <= (start_code != vertex_hi);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        ovr_q   <= 1'b0;
                    end else if (go_rej) begin
                        cfg_err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (advance) begin
                        code_q  <= nxt_code;
                        phase   <= nxt_phase;
                        dir_q   <= nxt_dir;
                        valid_q <= 1'b1;
                        if (cyc_end) cyc_q <= cyc_q + CYC_W'(1);
                    end else if (ovr_hit) begin
                        ovr_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (abort || hs) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dac.dac_code  = code_q;
    assign dac.dac_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign overrun       = ovr_q;
    assign dir_up        = dir_q;
    assign cycle_count   = cyc_q;
endmodule

// File: tb/tb_bioee_sweep_sequencer.sv
// Scoreboard bench: expected DAC codes are queued at stimulus time, a monitor pops on each handshake.
module tb_bioee_sweep_sequencer;
    logic        clkin = 1'b0;
    logic        rstn = 1'b0;
    logic        step_clk = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] start_code = '0, vertex_hi = '0, vertex_lo = '0, step_size = '0;
    logic [7:0]  num_cycles = '0;
    logic        busy, done, cfg_err, overrun, dir_up;
    logic [7:0]  cycle_count;

    bioee_sweep_sequencer_if #(.CODE_W(16)) dac ();

    bioee_sweep_sequencer #(.CODE_W(16), .CYC_W(8)) dut (
        .clkin       (clkin),
        .rstn        (rstn),
        .step_clk    (step_clk),
        .go          (go),
        .abort       (abort),
        .start_code  (start_code),
        .vertex_hi   (vertex_hi),
        .vertex_lo   (vertex_lo),
        .step_size   (step_size),
        .num_cycles  (num_cycles),
        .dac         (dac),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .overrun     (overrun),
        .dir_up      (dir_up),
        .cycle_count (cycle_count)
    );

    always #5 clkin = ~clkin;

    // Divide-by-4 step clock, as produced by the clock divider.
    logic [1:0] div_cnt = '0;
    always @(posedge clkin) begin
        div_cnt <= div_cnt + 2'd1;
        if (div_cnt[0]) step_clk <= ~step_clk;
    end

    int n_vec = 0, n_err = 0, n_pop = 0, n_done = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clkin) begin
        if (rstn && done) n_done++;
        if (rstn && dac.dac_valid && dac.dac_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_sample: got %0d, expected no sample", dac.dac_code);
            end else begin
                chk("dac_code", int'(dac.dac_code), exp_q.pop_front());
            end
        end
    end

    task automatic start_sweep(input int s, input int h, input int l, input int st, input int c);
        @(negedge clkin);
        start_code = 16'(s); vertex_hi = 16'(h); vertex_lo = 16'(l);
        step_size = 16'(st); num_cycles = 8'(c);
        go = 1'b1;
        @(negedge clkin);
        go = 1'b0;
        // Configuration is latched at go; scrambling it must not disturb the sweep.
        start_code = 16'd7; vertex_hi = 16'd9; vertex_lo = 16'd3; step_size = 16'd1; num_cycles = 8'd9;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 400 && !done; i++) @(negedge clkin);
        chk({name, "_done_seen"}, int'(done), 1);
    endtask

    task automatic wait_pops(input int target, input string name);
        for (int i = 0; i < 400 && n_pop < target; i++) @(negedge clkin);
        chk({name, "_pop_wait"}, int'(n_pop >= target), 1);
    endtask

    int v1 [9]  = '{100, 105, 110, 105, 100, 95, 90, 95, 100};
    int v2 [16] = '{100, 103, 106, 109, 110, 107, 104, 101, 98, 95, 92, 90, 93, 96, 99, 100};

    initial begin
        int d0, p0, k, last;
        dac.dac_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clkin);
        chk("rst_code", int'(dac.dac_code), 0);
        chk("rst_valid", int'(dac.dac_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_dir_up", int'(dir_up), 1);
        chk("rst_cycles", int'(cycle_count), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clkin);

        // Single cycle, step 5
        foreach (v1[i]) exp_q.push_back(v1[i]);
        d0 = n_done;
        start_sweep(100, 110, 90, 5, 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_overrun_cleared", int'(overrun), 0);
        wait_done("t1");
        @(negedge clkin);
        chk("t1_left", exp_q.size(), 0);
        chk("t1_cycles", int'(cycle_count), 1);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_done_cnt", n_done - d0, 1);

        // Step 3: clamping at both vertices and at start
        foreach (v2[i]) exp_q.push_back(v2[i]);
        start_sweep(100, 110, 90, 3, 1);
        wait_done("t2");
        @(negedge clkin);
        chk("t2_left", exp_q.size(), 0);

        // Three cycles: cycle_count steps 1,2,3, 25 samples, one done
        exp_q.push_back(100);
        for (int c = 0; c < 3; c++)
            for (int i = 1; i < 9; i++) exp_q.push_back(v1[i]);
        d0 = n_done; p0 = n_pop; k = 0; last = 0;
        start_sweep(100, 110, 90, 5, 3);
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clkin);
            if (int'(cycle_count) != last) begin
                k++;
                chk("t3_cycle_step", int'(cycle_count), k);
                last = int'(cycle_count);
            end
        end
        chk("t3_done_seen", int'(done), 1);
        repeat (4) @(negedge clkin);
        chk("t3_cycles", int'(cycle_count), 3);
        chk("t3_samples", n_pop - p0, 25);
        chk("t3_done_cnt", n_done - d0, 1);

        // Back-pressure across two ticks: code holds, overrun set
        dac.dac_ready = 1'b0;
        foreach (v1[i]) exp_q.push_back(v1[i]);
        start_sweep(100, 110, 90, 5, 1);
        repeat (10) @(negedge clkin);
        chk("t4_hold_code", int'(dac.dac_code), 100);
        chk("t4_hold_valid", int'(dac.dac_valid), 1);
        chk("t4_overrun", int'(overrun), 1);
        dac.dac_ready = 1'b1;
        wait_done("t4");
        @(negedge clkin);
        chk("t4_left", exp_q.size(), 0);
        chk("t4_overrun_sticky", int'(overrun), 1);

        // Rejected go: start above vertex_hi, then zero step
        for (int t = 0; t < 2; t++) begin
            @(negedge clkin);
            start_code = (t == 0) ? 16'd120 : 16'd100;
            vertex_hi = 16'd110; vertex_lo = 16'd90;
            step_size = (t == 0) ? 16'd5 : 16'd0;
            num_cycles = 8'd1;
            go = 1'b1;
            @(negedge clkin);
            go = 1'b0;
            chk("t5_cfg_err", int'(cfg_err), 1);
            chk("t5_busy", int'(busy), 0);
            chk("t5_valid", int'(dac.dac_valid), 0);
            @(negedge clkin);
            chk("t5_cfg_err_pulse", int'(cfg_err), 0);
            chk("t5_valid_after", int'(dac.dac_valid), 0);
        end

        // Abort after the third sample
        exp_q.push_back(100); exp_q.push_back(105); exp_q.push_back(110);
        p0 = n_pop; d0 = n_done;
        start_sweep(100, 110, 90, 5, 1);
        chk("t6_overrun_cleared", int'(overrun), 0);
        wait_pops(p0 + 3, "t6");
        abort = 1'b1;
        @(negedge clkin);
        abort = 1'b0;
        chk("t6_valid", int'(dac.dac_valid), 0);
        chk("t6_done", int'(done), 1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_code_hold", int'(dac.dac_code), 110);
        repeat (12) @(negedge clkin);
        chk("t6_idle_valid", int'(dac.dac_valid), 0);
        chk("t6_done_cnt", n_done - d0, 1);

        // Reset mid-sweep: immediate return to reset values, no done
        exp_q.push_back(100); exp_q.push_back(105);
        p0 = n_pop; d0 = n_done;
        start_sweep(100, 110, 90, 5, 2);
        wait_pops(p0 + 2, "t7");
        rstn = 1'b0;
        @(negedge clkin);
        chk("t7_code", int'(dac.dac_code), 0);
        chk("t7_valid", int'(dac.dac_valid), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_dir_up", int'(dir_up), 1);
        chk("t7_cycles", int'(cycle_count), 0);
        chk("t7_done_now", int'(done), 0);
        rstn = 1'b1;
        repeat (12) @(negedge clkin);
        chk("t7_done_cnt", n_done - d0, 0);
        chk("t7_valid_idle", int'(dac.dac_valid), 0);
        chk("final_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
